// File: rtl/truth_table_sweeper_pkg.sv
// Shared state encoding and the vector-width helper for the truth-table sweeper.
package truth_table_sweeper_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_DRIVE  = 2'd1;
    localparam state_t ST_SAMPLE = 2'd2;
    localparam state_t ST_FINISH = 2'd3;

    // One vector bit per input combination.
    function automatic int vec_width(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// Loadable down-counter that holds stim for SETTLE_CYCLES before the sample.
// One-cycle load-to-count latency; load wins over en; no backpressure.
module sweep_settle_timer #(
    parameter int SETTLE_CYCLES = 2,
    localparam int W = $clog2(SETTLE_CYCLES) + 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic zero
);

    localparam logic [W-1:0] RELOAD = W'(SETTLE_CYCLES - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = RELOAD;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all 2**N_IN stim values, samples resp after SETTLE_CYCLES, builds vector + ones count.
// Each combination takes SETTLE_CYCLES+1 cycles; start is ignored while a sweep is in flight.
// SWEEP_COMPARE_EN adds an expected-vector input and a registered mismatch flag.
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int N_IN          = 4,
    parameter int SETTLE_CYCLES = 2,
    localparam int VW = vec_width(N_IN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            resp,
`ifdef SWEEP_COMPARE_EN
    input  logic [VW-1:0]   expected,
    output logic            mismatch,
`endif
    output logic [N_IN-1:0] stim,
    output logic            busy,
    output logic            done,
    output logic [VW-1:0]   vector,
    output logic [N_IN:0]   ones_count
);

    localparam logic [N_IN-1:0] STIM_MAX = '1;

    state_t          state_q, state_d;
    logic [N_IN-1:0] stim_q, stim_d;
    logic [VW-1:0]   vector_q, vector_d;
    logic [N_IN:0]   ones_q, ones_d;
    logic            tmr_load, tmr_en, tmr_zero;

    sweep_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load),
        .en    (tmr_en),
        .zero  (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        stim_d   = stim_q;
        vector_d = vector_q;
        ones_d   = ones_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_DRIVE;
                    stim_d   = '0;
                    vector_d = '0;
                    ones_d   = '0;
                    tmr_load = 1'b1;
                end
            end
            ST_DRIVE: begin
                tmr_en = 1'b1;
                if (tmr_zero) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                vector_d[stim_q] = resp;
                ones_d           = ones_q + (N_IN+1)'(resp);
                // The last combination holds stim rather than wrapping to 0.
                if (stim_q != STIM_MAX) begin
                    stim_d   = stim_q + N_IN'(1);
                    tmr_load = 1'b1;
                    state_d  = ST_DRIVE;
                end else begin
                    state_d = ST_FINISH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            stim_q   <= '0;
            vector_q <= '0;
            ones_q   <= '0;
        end else begin
            state_q  <= state_d;
            stim_q   <= stim_d;
            vector_q <= vector_d;
            ones_q   <= ones_d;
        end
    end

    assign stim       = stim_q;
    assign busy       = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
    assign done       = (state_q == ST_FINISH);
    assign vector     = vector_q;
    assign ones_count = ones_q;

`ifdef SWEEP_COMPARE_EN
    logic mismatch_q, mismatch_d;

    always_comb begin
        mismatch_d = mismatch_q;
        if ((state_q == ST_IDLE) && start) begin
            mismatch_d = 1'b0;
        end else if (state_q == ST_FINISH) begin
            mismatch_d = (vector_q != expected);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper (N_IN=4, SETTLE_CYCLES=2): table-driven sweeps, random truth tables, reset mid-sweep.
module tb_truth_table_sweeper;

    localparam int N_IN   = 4;
    localparam int SETTLE = 2;
    localparam int VW     = 1 << N_IN;
    localparam int PER    = SETTLE + 1;
    localparam int LAT    = VW * PER + 1;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic            resp;
    logic [N_IN-1:0] stim;
    logic            busy;
    logic            done;
    logic [VW-1:0]   vector;
    logic [N_IN:0]   ones_count;
`ifdef SWEEP_COMPARE_EN
    logic [VW-1:0]   exp_in;
    logic            mismatch;
`endif

    int            n_tests = 0;
    int            n_fail  = 0;
    int            cur_mode = 0;
    logic [VW-1:0] cur_tt = '0;
    logic          glitch = 1'b0;
    int            edge_k = 0;

    truth_table_sweeper #(.N_IN(N_IN), .SETTLE_CYCLES(SETTLE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .resp       (resp),
`ifdef SWEEP_COMPARE_EN
        .expected   (exp_in),
        .mismatch   (mismatch),
`endif
        .stim       (stim),
        .busy       (busy),
        .done       (done),
        .vector     (vector),
        .ones_count (ones_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Circuit under characterisation: mode 0 f=~A&D, 1 tied high, 2 tied low, 3 arbitrary table.
    function automatic logic model_f(input int mode, input logic [N_IN-1:0] s, input logic [VW-1:0] tt);
        case (mode)
            0:       return ~s[3] & s[0];
            1:       return 1'b1;
            2:       return 1'b0;
            default: return tt[s];
        endcase
    endfunction

    function automatic logic [VW-1:0] model_vec(input int mode, input logic [VW-1:0] tt);
        logic [VW-1:0] v;
        for (int i = 0; i < VW; i++) v[i] = model_f(mode, N_IN'(i), tt);
        return v;
    endfunction

    // Sweep cycles with edge_k % PER == PER-1 are the sampling cycles; the glitch inverts resp everywhere else.
    always_comb resp = model_f(cur_mode, stim, cur_tt) ^ (glitch && ((edge_k % PER) != PER - 1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic sweep(input string name, input logic [VW-1:0] exp_vec, input int exp_ones, input int dup_n);
        int first_done = 0;
        int ndone      = 0;
        int busy_after = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        edge_k = 0;
        for (int n = 1; n <= LAT + 12; n++) begin
            @(negedge clk);
            start = (n == dup_n);
            if (done) begin
                ndone++;
                if (first_done == 0) first_done = n;
            end
            if (n > LAT && busy) busy_after++;
            if (n == 2) begin
                chk({name, " busy"}, 32'(busy), 32'd1);
                chk({name, " cleared"}, 32'(vector) | 32'(ones_count), 32'd0);
            end
            if (n == LAT) chk({name, " busy_in_finish"}, 32'(busy), 32'd0);
            @(posedge clk);
            #1;
            edge_k = n;
        end
        start = 1'b0;
        chk({name, " done_latency"}, 32'(first_done), 32'(LAT));
        chk({name, " done_pulses"}, 32'(ndone), 32'd1);
        chk({name, " no_restart"}, 32'(busy_after), 32'd0);
        chk({name, " vector"}, 32'(vector), 32'(exp_vec));
        chk({name, " ones"}, 32'(ones_count), 32'(exp_ones));
        chk({name, " stim_held"}, 32'(stim), 32'(VW - 1));
`ifdef SWEEP_COMPARE_EN
        chk({name, " mismatch"}, 32'(mismatch), 32'(exp_vec != exp_in));
`endif
    endtask

    typedef struct {
        string         name;
        int            mode;
        logic          glitch;
        int            dup_n;
        logic [VW-1:0] exp_vec;
        int            exp_ones;
    } vec_t;

    vec_t tbl[6];

    initial begin
        // dup_n: negedge index at which a second start is pulsed (16 = combination 5, LAT = FINISH cycle).
        tbl[0] = '{"notA_and_D", 0, 1'b0, -1, 16'h00AA, 4};
        tbl[1] = '{"tied1",      1, 1'b0, -1, 16'hFFFF, 16};
        tbl[2] = '{"tied0",      2, 1'b0, -1, 16'h0000, 0};
        tbl[3] = '{"dup_start",  0, 1'b0, 16, 16'h00AA, 4};
        tbl[4] = '{"drive_glitch", 0, 1'b1, -1, 16'h00AA, 4};
        tbl[5] = '{"start_in_finish", 0, 1'b0, LAT, 16'h00AA, 4};

        start = 1'b0;
        rst_n = 1'b0;
`ifdef SWEEP_COMPARE_EN
        exp_in = 16'h00AA;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst stim", 32'(stim), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst vector", 32'(vector), 32'd0);
        chk("rst ones", 32'(ones_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 6; t++) begin
            cur_mode = tbl[t].mode;
            glitch   = tbl[t].glitch;
`ifdef SWEEP_COMPARE_EN
            exp_in = tbl[t].exp_vec;
`endif
            sweep(tbl[t].name, tbl[t].exp_vec, tbl[t].exp_ones, tbl[t].dup_n);
        end
        glitch = 1'b0;

        for (int r = 0; r < 4; r++) begin
            logic [VW-1:0] mv;
            cur_mode = 3;
            cur_tt   = VW'($urandom);
            glitch   = (r % 2) == 1;
            mv       = model_vec(3, cur_tt);
`ifdef SWEEP_COMPARE_EN
            exp_in = (r < 2) ? mv : mv ^ VW'(1 << $urandom_range(VW - 1, 0));
`endif
            sweep("random", mv, $countones(mv), -1);
        end
        glitch = 1'b0;

        // Reset in the middle of combination 9, then a clean sweep.
        cur_mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9 * PER) @(posedge clk);
        #1;
        chk("mid stim", 32'(stim), 32'd9);
        chk("mid busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst stim", 32'(stim), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        chk("midrst vector", 32'(vector), 32'd0);
        chk("midrst ones", 32'(ones_count), 32'd0);
`ifdef SWEEP_COMPARE_EN
        chk("midrst mismatch", 32'(mismatch), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
`ifdef SWEEP_COMPARE_EN
        exp_in = 16'h00AB;
`endif
        sweep("after_reset", model_vec(0, '0), $countones(model_vec(0, '0)), -1);

`ifdef SWEEP_COMPARE_EN
        exp_in = 16'h00AA;
        sweep("cmp_match", 16'h00AA, 4, -1);
        exp_in = 16'h00AB;
        sweep("cmp_miss", 16'h00AA, 4, -1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
